// File: rtl/shift_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_bank_pkg
// Description : Shared types for the shift register bank: shift mode
//               encoding and sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_bank_pkg;

    // Shift mode encoding, matches the 2-bit Mode input
    typedef enum logic [1:0] {
        LSR = 2'b00,    // logical shift right, Serial_In fills MSB
        ASR = 2'b01,    // arithmetic shift right, sign replicated
        ROR = 2'b10,    // rotate right, LSB wraps to MSB
        LSL = 2'b11     // logical shift left, Serial_In fills LSB
    } shift_mode_t;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } bank_state_t;

endpackage : shift_bank_pkg
`default_nettype wire

// File: rtl/reg_n.sv
`default_nettype none
// ============================================================================
// Module      : reg_n
// Description : WIDTH-bit register with parallel load and 1-bit shift in
//               either direction. Exposes both end bits so neighbours can be
//               chained into a longer shift path. Requires WIDTH >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_n #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_shift,
    input  logic             i_dir_left,
    input  logic             i_in_msb,
    input  logic             i_in_lsb,
    output logic [WIDTH-1:0] o_q,
    output logic             o_msb,
    output logic             o_lsb
);

    logic [WIDTH-1:0] r_q;

    // Load has priority; otherwise shift one bit toward the selected end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_d;
        end else if (i_shift) begin
            if (i_dir_left) begin
                r_q <= {r_q[WIDTH-2:0], i_in_lsb};
            end else begin
                r_q <= {i_in_msb, r_q[WIDTH-1:1]};
            end
        end
    end

    assign o_q   = r_q;
    assign o_msb = r_q[WIDTH-1];
    assign o_lsb = r_q[0];

endmodule : reg_n
`default_nettype wire

// File: rtl/shift_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : shift_register_bank
// Description : NUM_REGS chained WIDTH-bit registers forming one serial
//               shift path (register 0 most significant), with individual
//               parallel load and a Start/Busy/Done shift sequencer
//               supporting LSR, ASR, ROR and LSL.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_register_bank
    import shift_bank_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int NUM_REGS = 2,
    parameter int TOT_W    = NUM_REGS * WIDTH,
    parameter int SEL_W    = $clog2(NUM_REGS),
    parameter int CNT_W    = $clog2(TOT_W + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Ld,
    input  logic [SEL_W-1:0] Ld_Sel,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic [CNT_W-1:0] Shift_Cnt,
    input  logic [1:0]       Mode,
    input  logic             Serial_In,
    output logic             Serial_Out,
    output logic             Busy,
    output logic             Done,
    output logic [TOT_W-1:0] Data_Out
);

    bank_state_t      r_state;
    shift_mode_t      r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic             w_idle;
    logic             w_shift;
    logic             w_left;
    logic             w_fill_msb;
    shift_mode_t      w_mode_eff;

    logic [WIDTH-1:0] w_q   [NUM_REGS];
    logic             w_msb [NUM_REGS];
    logic             w_lsb [NUM_REGS];

    assign w_idle  = (r_state == IDLE);
    assign w_shift = (r_state == SHIFT);
    assign w_left  = (r_mode == LSL);

    // Bit entering the chain MSB on right-going shifts
    always_comb begin
        w_fill_msb = Serial_In;
        case (r_mode)
            LSR:     w_fill_msb = Serial_In;
            ASR:     w_fill_msb = w_msb[0];
            ROR:     w_fill_msb = w_lsb[NUM_REGS-1];
            default: w_fill_msb = Serial_In;
        endcase
    end

    // Serial_Out previews the bit leaving on the next shift; the live Mode
    // is used only while idle, before a mode has been latched
    assign w_mode_eff = w_idle ? shift_mode_t'(Mode) : r_mode;
    assign Serial_Out = (w_mode_eff == LSL) ? w_msb[0] : w_lsb[NUM_REGS-1];

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
            logic w_in_msb;
            logic w_in_lsb;
            logic w_ld;

            // Out-of-range Ld_Sel matches no register and is dropped
            assign w_ld = Ld && w_idle && (Ld_Sel == SEL_W'(k));

            if (k == 0) begin : g_head
                assign w_in_msb = w_fill_msb;
            end else begin : g_mid_msb
                assign w_in_msb = w_lsb[k-1];
            end

            if (k == NUM_REGS - 1) begin : g_tail
                assign w_in_lsb = Serial_In;
            end else begin : g_mid_lsb
                assign w_in_lsb = w_msb[k+1];
            end

            reg_n #(
                .WIDTH (WIDTH)
            ) u_reg (
                .clk        (Clk),
                .rst        (Reset),
                .i_ld       (w_ld),
                .i_d        (D),
                .i_shift    (w_shift),
                .i_dir_left (w_left),
                .i_in_msb   (w_in_msb),
                .i_in_lsb   (w_in_lsb),
                .o_q        (w_q[k]),
                .o_msb      (w_msb[k]),
                .o_lsb      (w_lsb[k])
            );

            assign Data_Out[TOT_W-1-k*WIDTH -: WIDTH] = w_q[k];
        end
    endgenerate

    // Sequencer: accept Start in IDLE, count shifts, pulse Done once
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_mode  <= LSR;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_mode <= shift_mode_t'(Mode);
                        r_cnt  <= Shift_Cnt;
                        if (Shift_Cnt == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = r_busy;
    assign Done = r_done;

endmodule : shift_register_bank
`default_nettype wire

// File: tb/tb_shift_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_register_bank
// Description : Self-checking bench for shift_register_bank (WIDTH=4,
//               NUM_REGS=2): table of complete shift operations plus
//               hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_register_bank;

    localparam int WIDTH    = 4;
    localparam int NUM_REGS = 2;
    localparam int TOT_W    = 8;
    localparam int SEL_W    = 1;
    localparam int CNT_W    = 4;

    localparam logic [1:0] M_LSR = 2'b00;
    localparam logic [1:0] M_ASR = 2'b01;
    localparam logic [1:0] M_ROR = 2'b10;
    localparam logic [1:0] M_LSL = 2'b11;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Ld = 1'b0;
    logic [SEL_W-1:0] Ld_Sel = '0;
    logic [WIDTH-1:0] D = '0;
    logic             Start = 1'b0;
    logic [CNT_W-1:0] Shift_Cnt = '0;
    logic [1:0]       Mode = M_LSR;
    logic             Serial_In = 1'b0;
    logic             Serial_Out;
    logic             Busy;
    logic             Done;
    logic [TOT_W-1:0] Data_Out;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] val;
        logic [1:0] mode;
        logic [3:0] cnt;
        logic       sin;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [9];

    shift_register_bank #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Ld         (Ld),
        .Ld_Sel     (Ld_Sel),
        .D          (D),
        .Start      (Start),
        .Shift_Cnt  (Shift_Cnt),
        .Mode       (Mode),
        .Serial_In  (Serial_In),
        .Serial_Out (Serial_Out),
        .Busy       (Busy),
        .Done       (Done),
        .Data_Out   (Data_Out)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] val);
        Ld     = 1'b1;
        Ld_Sel = sel;
        D      = val;
        tick();
        Ld     = 1'b0;
    endtask

    task automatic load_all(input logic [7:0] val);
        load(1'b0, val[7:4]);
        load(1'b1, val[3:0]);
    endtask

    task automatic start(input logic [1:0] m, input logic [3:0] c, input logic s);
        Mode      = m;
        Shift_Cnt = c;
        Serial_In = s;
        Start     = 1'b1;
        tick();
        Start     = 1'b0;
    endtask

    // Full operation: load, start, count Busy cycles, check Done pulse and result
    task automatic run_vec(input int idx, input vec_t v);
        int busy_cycles;
        int guard;
        string tag;
        tag = $sformatf("vec%0d", idx);
        load_all(v.val);
        check({tag, "_load"}, 32'(Data_Out), 32'(v.val));
        start(v.mode, v.cnt, v.sin);
        busy_cycles = 0;
        guard = 0;
        while (!Done && guard < 40) begin
            if (Busy) busy_cycles++;
            tick();
            guard++;
        end
        check({tag, "_done_seen"}, 32'(Done), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(v.cnt));
        check({tag, "_data"}, 32'(Data_Out), 32'(v.exp));
        tick();
        check({tag, "_done_one_cycle"}, 32'(Done), 32'd0);
    endtask

    initial begin : main
        logic [7:0] asr_seq [3];
        logic       ror_so  [8];
        int         done_cnt;

        vecs[0] = '{val: 8'hA5, mode: M_LSR, cnt: 4'd1,  sin: 1'b0, exp: 8'h52};
        vecs[1] = '{val: 8'h96, mode: M_ASR, cnt: 4'd3,  sin: 1'b0, exp: 8'hF2};
        vecs[2] = '{val: 8'h3C, mode: M_ROR, cnt: 4'd8,  sin: 1'b0, exp: 8'h3C};
        vecs[3] = '{val: 8'h81, mode: M_LSL, cnt: 4'd4,  sin: 1'b1, exp: 8'h1F};
        vecs[4] = '{val: 8'h5A, mode: M_ROR, cnt: 4'd11, sin: 1'b0, exp: 8'h4B};
        vecs[5] = '{val: 8'h80, mode: M_ASR, cnt: 4'd8,  sin: 1'b0, exp: 8'hFF};
        vecs[6] = '{val: 8'h01, mode: M_LSR, cnt: 4'd3,  sin: 1'b1, exp: 8'hE0};
        vecs[7] = '{val: 8'h6B, mode: M_LSR, cnt: 4'd0,  sin: 1'b1, exp: 8'h6B};
        vecs[8] = '{val: 8'h80, mode: M_LSL, cnt: 4'd1,  sin: 1'b0, exp: 8'h00};

        asr_seq = '{8'hCB, 8'hE5, 8'hF2};
        ror_so  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state
        #2;
        check("reset_data", 32'(Data_Out), 32'h00);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        tick();
        Reset = 1'b0;
        tick();

        // Table of complete operations
        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // LSR by 1: Serial_Out before and after, latency of Busy/Done
        load_all(8'hA5);
        Mode = M_LSR;
        #1;
        check("lsr_so_before", 32'(Serial_Out), 32'd1);
        start(M_LSR, 4'd1, 1'b0);
        check("lsr_busy", 32'(Busy), 32'd1);
        check("lsr_no_shift_yet", 32'(Data_Out), 32'hA5);
        tick();
        check("lsr_data", 32'(Data_Out), 32'h52);
        check("lsr_so_after", 32'(Serial_Out), 32'd0);
        check("lsr_done", 32'(Done), 32'd1);
        check("lsr_busy_low", 32'(Busy), 32'd0);
        tick();

        // ASR per-edge values
        load_all(8'h96);
        start(M_ASR, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("asr_busy_%0d", i), 32'(Busy), 32'd1);
            tick();
            check($sformatf("asr_step_%0d", i), 32'(Data_Out), 32'(asr_seq[i]));
        end
        check("asr_done", 32'(Done), 32'd1);
        tick();

        // ROR Serial_Out sequence over a full rotation
        load_all(8'h3C);
        start(M_ROR, 4'd8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ror_so_%0d", i), 32'(Serial_Out), 32'(ror_so[i]));
            tick();
        end
        check("ror_return", 32'(Data_Out), 32'h3C);
        check("ror_done", 32'(Done), 32'd1);
        tick();

        // Count 0: Busy never asserts, Done next cycle, data unchanged
        load_all(8'h5C);
        start(M_ROR, 4'd0, 1'b0);
        check("cnt0_busy", 32'(Busy), 32'd0);
        check("cnt0_done", 32'(Done), 32'd1);
        check("cnt0_data", 32'(Data_Out), 32'h5C);
        tick();

        // Ld and Start in the same cycle: shifting uses the loaded value
        load_all(8'h00);
        Ld = 1'b1;
        Ld_Sel = 1'b0;
        D = 4'hC;
        start(M_LSR, 4'd1, 1'b1);
        Ld = 1'b0;
        check("ldstart_loaded", 32'(Data_Out), 32'hC0);
        tick();
        check("ldstart_shifted", 32'(Data_Out), 32'hE0);
        tick();

        // Mid-shift Ld/Start/Mode ignored, then reset mid-shift
        load_all(8'hFF);
        start(M_LSR, 4'd5, 1'b0);
        tick();
        check("mid_step1", 32'(Data_Out), 32'h7F);
        Mode = M_LSL;
        #1;
        check("mid_so_latched_mode", 32'(Serial_Out), 32'd1);
        Mode = M_ROR;
        Ld = 1'b1;
        Ld_Sel = 1'b1;
        D = 4'h0;
        Start = 1'b1;
        tick();
        Ld = 1'b0;
        Start = 1'b0;
        check("mid_step2_ignored", 32'(Data_Out), 32'h3F);
        Reset = 1'b1;
        #1;
        check("mid_reset_data", 32'(Data_Out), 32'h00);
        check("mid_reset_busy", 32'(Busy), 32'd0);
        tick();
        Reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (Done) done_cnt++;
            tick();
        end
        check("mid_reset_no_done", 32'(done_cnt), 32'd0);

        // Normal operation after reset
        run_vec(100, vecs[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_shift_register_bank
`default_nettype wire

// File: doc/shift_register_bank.md
Name: shift_register_bank

Overview:
- Parametrised bank of NUM_REGS registers, each WIDTH bits, chained into one serial shift path. Register 0 is most significant; its LSB feeds register 1's MSB, and so on.
- Each register can be parallel-loaded individually.
- Contains a shift sequencer: Start plus a shift count launches a multi-cycle shift in one of four modes, with Busy/Done handshake.
- Datapath core for the add-shift multiplier and the serial logic processor; replaces the fixed two-register 4-bit pair.

Parameters:
- WIDTH, 4, bits per register
- NUM_REGS, 2, number of chained registers (at least 2)
- TOT_W, NUM_REGS*WIDTH, total chain width (derived; not overridden)
- SEL_W, $clog2(NUM_REGS), width of load select
- CNT_W, $clog2(TOT_W+1), width of shift count

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Ld  in  1  parallel-load strobe
- Ld_Sel  in  SEL_W  index of register to load
- D  in  WIDTH  parallel load data
- Start  in  1  launch shift sequence
- Shift_Cnt  in  CNT_W  number of single-bit shifts
- Mode  in  2  00 LSR, 01 ASR, 10 ROR, 11 LSL
- Serial_In  in  1  fill bit for LSR/LSL
- Serial_Out  out  1  bit leaving chain: LSB in right modes, MSB in LSL; follows the latched mode, or Mode while IDLE
- Busy  out  1  high while shifting
- Done  out  1  one-cycle completion pulse
- Data_Out  out  TOT_W  concatenated register contents, register 0 in MSBs

Behaviour:
- Reset, asynchronous:
  - all registers 0, FSM to IDLE
  - Busy=0, Done=0, internal count 0, latched mode LSR
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - Ld=1 writes D into register Ld_Sel at the clock edge.
  - Ld_Sel >= NUM_REGS is ignored.
  - Start=1 latches Mode and Shift_Cnt.
  - If Shift_Cnt=0, go to DONE; otherwise go to SHIFT.
- Ld and Start in the same IDLE cycle: the load is applied, and shifting operates on the loaded value from the next edge.
- SHIFT:
  - Busy=1.
  - Each edge performs one 1-bit shift of the whole TOT_W chain and decrements the count.
  - When the count reaches 1, that edge performs the last shift and the FSM goes to DONE.
  - N shifts occur on N consecutive edges after acceptance; Busy is high for exactly N cycles.
- Shift rules, per edge:
  - LSR: MSB <= Serial_In, sampled each shift cycle.
  - ASR: MSB <= current MSB, so the sign is replicated.
  - ROR: MSB <= current LSB.
  - LSL: LSB <= Serial_In, sampled each shift cycle; the MSB is discarded.
  - Bits always cross register boundaries; there is no per-register isolation.
- DONE: Done=1 for exactly one cycle, Busy=0, then IDLE. A new Start is accepted only in IDLE.
- Ignored inputs:
  - Start in SHIFT or DONE is ignored.
  - Ld in SHIFT or DONE is ignored, so data stays consistent.
  - Mode changes during SHIFT are ignored; the latched mode applies.
- Shift_Cnt > TOT_W is legal: it performs that many shifts (ROR wraps as expected).
- Reset asserted mid-shift: immediate clear per the reset rule; no Done is produced.
- Serial_Out is combinational from the current register state; it reflects the bit that will leave on the next shift.

Decomposition:
- Package shift_bank_pkg holds:
  - shift_mode_t enum: LSR=2'b00, ASR=2'b01, ROR=2'b10, LSL=2'b11
  - bank_state_t enum: IDLE, SHIFT, DONE
- Sub-module reg_n, parametrised by WIDTH:
  - parallel load, 1-bit shift in either direction, with shift-in and shift-out bits for each end
  - instantiated NUM_REGS times via generate
- Sequencer FSM, counter, and chain-end fill muxing live in shift_register_bank.

Test Plan (WIDTH=4, NUM_REGS=2):
- Reset, then load reg0=0xA and reg1=0x5. Data_Out=0xA5. Start, Cnt=1, LSR, Serial_In=0 -> Data_Out=0x52 one edge later. Serial_Out=1 before the shift, 0 after. Busy for 1 cycle, Done pulse next cycle.
- Load 0x96, Start Cnt=3 ASR -> Data_Out 0xCB, 0xE5, 0xF2 on successive edges. Busy exactly 3 cycles, then a single-cycle Done.
- Load 0x3C, Start Cnt=8 ROR -> Data_Out returns to 0x3C after 8 edges. Serial_Out sequence is 0,0,1,1,1,1,0,0.
- Load 0x81, Start Cnt=4 LSL, Serial_In=1 -> Data_Out=0x1F.
- Start Cnt=0 -> Busy never asserts, Done high in the next cycle, Data_Out unchanged. Ld and Start in the same cycle -> shifting uses the loaded data.
- Start Cnt=5 on 0xFF in LSR with Serial_In=0:
  - Ld and Start pulsed mid-shift are ignored.
  - Reset asserted after 2 shifts -> Data_Out=0x00, Busy=0 immediately, no Done afterwards.
  - Next Start works normally.
